// File: rtl/valu_seq_ctrl_pkg.sv
// Shared definitions for the vector-ALU sequencer: ALU opcodes,
// vfunct encodings ({funct7[5:0], vector bit, funct3}) and FSM states.
package valu_seq_ctrl_pkg;

    // ALU opcodes driven on VALUCtrl_o
    localparam logic [2:0] OP_SMUL = 3'b000;
    localparam logic [2:0] OP_DOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_NONE = 3'b000;

    // Recognised vfunct values
    localparam logic [9:0] VF_ADD  = 10'b000000_1_001;
    localparam logic [9:0] VF_SUB  = 10'b010000_1_000;
    localparam logic [9:0] VF_SMUL = 10'b000000_1_111;
    localparam logic [9:0] VF_DOT  = 10'b000000_1_110;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_REDUCE  = 3'd2,
        S_DONE    = 3'd3,
        S_ILLEGAL = 3'd4
    } state_t;

endpackage

// File: rtl/valu_seq_ctrl_decode.sv
// Combinational vfunct decoder: maps a vfunct word to an ALU opcode,
// flags dot-product ops and unrecognised encodings. Kept standalone so
// issue logic can reuse it for early illegal detection.
module valu_seq_ctrl_decode
    import valu_seq_ctrl_pkg::*;
(
    input  logic [9:0] vfunct,
    output logic [2:0] opcode,
    output logic       is_dot,
    output logic       illegal
);

    // Table lookup; anything not listed is illegal with a neutral opcode
    always_comb begin
        opcode  = OP_NONE;
        is_dot  = 1'b0;
        illegal = 1'b0;
        case (vfunct)
            VF_ADD:  opcode = OP_ADD;
            VF_SUB:  opcode = OP_SUB;
            VF_SMUL: opcode = OP_SMUL;
            VF_DOT: begin
                opcode = OP_DOT;
                is_dot = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/valu_seq_ctrl.sv
// Vector-ALU sequencer. Accepts an op from issue logic, then walks vl
// elements LANES at a time, driving per-beat opcode, element index, lane
// mask, dot-product accumulator controls and the writeback strobe.
// Handshake: a request is taken on a rising edge where valid_i and
// ready_o are both high and flush_i is low; ready_o is high only in IDLE
// outside reset. All outputs except ready_o are registered.
module valu_seq_ctrl
    import valu_seq_ctrl_pkg::*;
#(
    parameter  int VLEN  = 8,
    parameter  int LANES = 2,
    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [9:0]       vfunct_i,
    input  logic [IDX_W:0]   vl_i,
    output logic [2:0]       VALUCtrl_o,
    output logic [IDX_W-1:0] elem_idx_o,
    output logic [LANES-1:0] lane_en_o,
    output logic             acc_clr_o,
    output logic             acc_en_o,
    output logic             wb_en_o,
    output logic             done_o,
    output logic             illegal_o
);

    localparam logic [IDX_W:0]   VLEN_V  = (IDX_W + 1)'(VLEN);
    localparam logic [IDX_W+1:0] LANES_V = (IDX_W + 2)'(LANES);

    state_t           state;
    logic [2:0]       op_q;
    logic             is_dot_q;
    logic [IDX_W:0]   vl_q;

    logic [2:0]       dec_op;
    logic             dec_dot;
    logic             dec_illegal;
    logic [IDX_W:0]   vl_clamp;
    logic [IDX_W+1:0] next_ext;
    logic             last_beat;
    logic [IDX_W-1:0] next_idx;

    valu_seq_ctrl_decode u_decode (
        .vfunct  (vfunct_i),
        .opcode  (dec_op),
        .is_dot  (dec_dot),
        .illegal (dec_illegal)
    );

    // Lane k is live when its element index is still below vl
    function automatic logic [LANES-1:0] lane_mask(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W:0]   vl);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            m[k] = (({2'b00, idx} + (IDX_W + 2)'(k)) < {1'b0, vl});
        end
        return m;
    endfunction

    // Request shaping and beat arithmetic (widened so idx+LANES never wraps)
    always_comb begin
        ready_o   = (state == S_IDLE) && !rst_i;
        vl_clamp  = (vl_i > VLEN_V) ? VLEN_V : vl_i;
        next_ext  = {2'b00, elem_idx_o} + LANES_V;
        last_beat = (next_ext >= {1'b0, vl_q});
        next_idx  = next_ext[IDX_W-1:0];
    end

    // Sequencer FSM; outputs are registered alongside the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            op_q       <= OP_NONE;
            is_dot_q   <= 1'b0;
            vl_q       <= '0;
            VALUCtrl_o <= OP_NONE;
            elem_idx_o <= '0;
            lane_en_o  <= '0;
            acc_clr_o  <= 1'b0;
            acc_en_o   <= 1'b0;
            wb_en_o    <= 1'b0;
            done_o     <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            VALUCtrl_o <= OP_NONE;
            elem_idx_o <= '0;
            lane_en_o  <= '0;
            acc_clr_o  <= 1'b0;
            acc_en_o   <= 1'b0;
            wb_en_o    <= 1'b0;
            done_o     <= 1'b0;
            illegal_o  <= 1'b0;
            if (flush_i) begin
                state    <= S_IDLE;
                op_q     <= OP_NONE;
                is_dot_q <= 1'b0;
                vl_q     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (valid_i) begin
                            if (dec_illegal) begin
                                state     <= S_ILLEGAL;
                                illegal_o <= 1'b1;
                            end else if (vl_clamp == '0) begin
                                state  <= S_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state      <= S_EXEC;
                                op_q       <= dec_op;
                                is_dot_q   <= dec_dot;
                                vl_q       <= vl_clamp;
                                VALUCtrl_o <= dec_op;
                                lane_en_o  <= lane_mask('0, vl_clamp);
                                wb_en_o    <= !dec_dot;
                                acc_en_o   <= dec_dot;
                                acc_clr_o  <= dec_dot;
                            end
                        end
                    end
                    S_EXEC: begin
                        if (!last_beat) begin
                            VALUCtrl_o <= op_q;
                            elem_idx_o <= next_idx;
                            lane_en_o  <= lane_mask(next_idx, vl_q);
                            wb_en_o    <= !is_dot_q;
                            acc_en_o   <= is_dot_q;
                        end else if (is_dot_q) begin
                            state      <= S_REDUCE;
                            VALUCtrl_o <= OP_DOT;
                            wb_en_o    <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end
                    S_REDUCE: begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                    S_DONE, S_ILLEGAL: begin
                        state    <= S_IDLE;
                        op_q     <= OP_NONE;
                        is_dot_q <= 1'b0;
                        vl_q     <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_valu_seq_ctrl.sv
// Self-checking bench for valu_seq_ctrl (VLEN=8, LANES=2). Each issued op
// pushes its expected per-cycle output words onto a queue; the words are
// popped and compared cycle by cycle as the DUT sequences the op.
module tb_valu_seq_ctrl;

    localparam int W = 13;  // {opcode[3], idx[3], lane_en[2], clr, en, wb, done, illegal}

    logic       clk;
    logic       rst;
    logic       flush;
    logic       valid;
    logic       ready;
    logic [9:0] vfunct;
    logic [3:0] vlen;
    logic [2:0] valu_ctrl;
    logic [2:0] elem_idx;
    logic [1:0] lane_en;
    logic       acc_clr;
    logic       acc_en;
    logic       wb_en;
    logic       done;
    logic       illegal;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;

    valu_seq_ctrl #(.VLEN(8), .LANES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .valid_i    (valid),
        .ready_o    (ready),
        .vfunct_i   (vfunct),
        .vl_i       (vlen),
        .VALUCtrl_o (valu_ctrl),
        .elem_idx_o (elem_idx),
        .lane_en_o  (lane_en),
        .acc_clr_o  (acc_clr),
        .acc_en_o   (acc_en),
        .wb_en_o    (wb_en),
        .done_o     (done),
        .illegal_o  (illegal)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] obs();
        return {valu_ctrl, elem_idx, lane_en, acc_clr, acc_en, wb_en, done, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: expected output words for one request
    task automatic push_op(input logic [9:0] vf, input int vl);
        logic [2:0] op;
        logic       dot;
        logic       ill;
        logic [1:0] lanes;
        logic [2:0] idx;
        int         n;
        dot = 1'b0;
        ill = 1'b0;
        op  = 3'b000;
        case (vf)
            10'b0000001001: op = 3'b010;
            10'b0100001000: op = 3'b110;
            10'b0000001111: op = 3'b000;
            10'b0000001110: begin op = 3'b001; dot = 1'b1; end
            default:        ill = 1'b1;
        endcase
        if (ill) begin
            exp_q.push_back(13'b0000000_00000_1);
        end else begin
            n = (vl > 8) ? 8 : vl;
            for (int b = 0; 2 * b < n; b++) begin
                lanes = {(2 * b + 1 < n), (2 * b < n)};
                idx   = 3'(2 * b);
                exp_q.push_back({op, idx, lanes, dot && (b == 0), dot, !dot, 1'b0, 1'b0});
            end
            if (dot && n > 0) exp_q.push_back({3'b001, 3'b000, 2'b00, 5'b00100});
            exp_q.push_back({3'b000, 3'b000, 2'b00, 5'b00010});
        end
    endtask

    // Driver: present a request for one cycle, then scramble the inputs
    task automatic issue(input logic [9:0] vf, input int vl, input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        push_op(vf, vl);
        valid  = 1'b1;
        vfunct = vf;
        vlen   = 4'(vl);
        @(negedge clk);
        valid  = 1'b0;
        vfunct = 10'($urandom_range(0, 1023));
        vlen   = 4'($urandom_range(0, 15));
    endtask

    // Compare every queued word, one per cycle, then confirm idle
    task automatic drain(input string tag);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(obs()), 32'(e));
            @(negedge clk);
        end
        check({tag, "_idle"}, 32'({ready, obs()}), 32'({1'b1, 13'b0}));
    endtask

    task automatic run(input logic [9:0] vf, input int vl, input string tag);
        issue(vf, vl, tag);
        drain(tag);
    endtask

    initial begin
        logic [9:0] legal_tbl [4];
        n_checks = 0;
        n_errors = 0;
        legal_tbl[0] = 10'b0000001001;
        legal_tbl[1] = 10'b0100001000;
        legal_tbl[2] = 10'b0000001111;
        legal_tbl[3] = 10'b0000001110;

        rst    = 1'b1;
        flush  = 1'b0;
        valid  = 1'b0;
        vfunct = '0;
        vlen   = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({ready, obs()}), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_release", 32'({ready, obs()}), 32'({1'b1, 13'b0}));
        @(negedge clk);

        run(10'b0000001001, 8, "add_vl8");
        run(10'b0100001000, 5, "sub_vl5");
        run(10'b0000001110, 4, "dot_vl4");
        run(10'b0000001110, 8, "dot_vl8");
        run(10'b0000001111, 3, "smul_vl3");
        run(10'h3FF, 8, "illegal");
        run(10'b0000001001, 0, "add_vl0");
        run(10'b0000001001, 12, "add_clamp");
        run(10'b0000001110, 1, "dot_vl1");

        // Flush during the third beat of an add
        issue(10'b0000001001, 8, "flush");
        for (int i = 0; i < 3; i++) begin
            check("flush_beat", 32'(obs()), 32'(exp_q.pop_front()));
            if (i < 2) @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        check("flush_next", 32'({ready, obs()}), 32'({1'b1, 13'b0}));
        @(negedge clk);
        check("flush_no_done", 32'({ready, obs()}), 32'({1'b1, 13'b0}));

        // Flush wins over a request in IDLE
        valid  = 1'b1;
        flush  = 1'b1;
        vfunct = 10'b0000001001;
        vlen   = 4'd8;
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        check("vflush_c1", 32'({ready, obs()}), 32'({1'b1, 13'b0}));
        @(negedge clk);
        check("vflush_c2", 32'({ready, obs()}), 32'({1'b1, 13'b0}));

        // Reset in the middle of EXEC
        issue(10'b0000001001, 8, "rst_mid");
        check("rst_mid_beat0", 32'(obs()), 32'(exp_q.pop_front()));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", 32'({ready, obs()}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_release", 32'({ready, obs()}), 32'({1'b1, 13'b0}));
        @(negedge clk);

        // Back-to-back random legal ops
        for (int i = 0; i < 8; i++) begin
            run(legal_tbl[$urandom_range(0, 3)], int'($urandom_range(0, 15)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
